if_fetch_queue: RTL
===================

# if_fetch_queue

Parametrised instruction-fetch front end that replaces the single-cycle PC-plus-memory fetch stage. It generates sequential PCs and issues word requests to a valid/ready instruction memory with arbitrary in-order response latency. Requests and responses are tracked in a DEPTH-entry fetch queue, and {pc, instr} pairs are delivered to decode through a valid/ready handshake. A branch redirect flushes the queue and discards stale in-flight responses.

## Interface
- XLEN, 32: PC and instruction width.
- DEPTH, 4: fetch-queue entries; also the maximum number of memory requests in flight. Power of two, ≥2.
- ADDR_W, 10: word-address width to instruction memory.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_src  in  1  redirect request; sampled each cycle.
- branch_pc  in  XLEN  redirect target; valid while pc_src=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  ADDR_W  word address, equal to fetch_pc[ADDR_W+1:2].
- imem_rsp_valid  in  1  response valid. Responses arrive in order, at least 1 cycle after acceptance. No backpressure.
- imem_rsp_instr  in  XLEN  response data.
- out_valid  out  1  head entry is available to decode.
- out_ready  in  1  decode accepts the head entry; low means stall.
- out_pc  out  XLEN  PC of the head entry.
- out_instr  out  XLEN  instruction of the head entry.
- out_fault  out  1  misaligned-target fault. Present only when IF_MISALIGN_FAULT_EN is defined.

## Operation
- State:
  - fetch_pc.
  - Circular queue of DEPTH entries, each {pc, instr, filled}.
  - Pointers head (pop), fill (next entry awaiting a response) and tail (allocate), plus count.
  - drop_cnt, width clog2(DEPTH+1).
- Request:
  - imem_req_valid = !pc_src && (count + drop_cnt < DEPTH). This is purely registered state gated by pc_src; it never depends on imem_req_ready.
  - On accept: allocate the entry at tail with pc=fetch_pc and filled=0; tail+1; fetch_pc += 4, wrapping modulo 2^XLEN.
- Response:
  - If drop_cnt>0, discard the response and decrement drop_cnt.
  - Otherwise write instr into the entry at fill, set filled=1, fill+1.
- Output:
  - out_valid = (count>0) && head.filled && !pc_src.
  - out_pc and out_instr come from the head entry.
  - Pop on out_valid && out_ready: head+1, count-1.
- Simultaneous events: allocate and pop in the same cycle leaves count unchanged. A response filling the head entry in cycle N gives out_valid=1 in cycle N+1.
- Redirect (pc_src=1 at an edge), with priority over every other event:
  - Queue cleared: head=fill=tail, count=0.
  - fetch_pc <= {branch_pc[XLEN-1:2], 2'b00}.
  - drop_cnt <= drop_cnt + (allocated-but-unfilled entries) − (1 if a response is valid in this cycle).
  - No pop and no allocation happen in the redirect cycle.
- Back-to-back redirects: the later redirect wins. drop_cnt accumulates correctly.
- Full queue: count=DEPTH blocks requests. Responses always fit because every outstanding request holds an entry.
- Reset (asynchronous, at any time, including mid-transfer):
  - fetch_pc=RESET_PC; queue empty; drop_cnt=0.
  - imem_req_valid=0 while reset is asserted; out_valid=0, out_pc=0, out_instr=0, out_fault=0.
  - The environment also resets the memory, so no responses are dropped after reset.

## Timing
- First request in the first cycle after reset deassertion, at RESET_PC.
- Fetch-to-decode latency: memory latency L plus 1 cycle. With L=1 and out_ready held high, throughput is 1 instruction per cycle once the pipeline is primed.
- Redirect in cycle N: imem_req_valid=0 and out_valid=0 in cycle N; the first request at branch_pc is in cycle N+1.
- Redirect latency to decode: 1 + L + 1 cycles.

## Configuration
- IF_MISALIGN_FAULT_EN defined:
  - A redirect with branch_pc[1:0]≠0 does the normal flush and drop accounting.
  - It then enters a FAULT state: no requests are issued. Once the drops have completed, one entry is presented with out_fault=1, out_pc=branch_pc (unmasked) and out_instr=32'h0000_0013.
  - After that entry is popped, the block stays idle until the next redirect.
  - Any redirect leaves FAULT.
- IF_MISALIGN_FAULT_EN not defined: branch_pc[1:0] is ignored. There is no out_fault port and no FAULT state.

## Test plan
- Reset, memory with L=1, out_ready=1: out_pc = 0, 4, 8, 12 on consecutive cycles from cycle 2, each with the matching instruction.
- out_ready=0 for 10 cycles, DEPTH=4: exactly 4 requests are accepted and imem_req_valid stays 0 after that. When out_ready rises, PCs 0, 4, 8, 12 are delivered in order with none lost.
- L=3, 3 requests in flight, pc_src=1 with branch_pc=0x100: the 3 stale responses are discarded and the next out_pc is 0x100.
- Redirect in the same cycle as a response and a pop: drop_cnt is correct, head is not popped, and the first output is the target PC.
- Reset asserted mid-burst: outputs go to their reset values immediately, without waiting for a clock edge. After release, fetching restarts at RESET_PC.
- With the macro defined, branch_pc=0x102: one output with out_fault=1, out_pc=0x102, out_instr=0x13. No imem requests are issued until the next redirect.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, DEPTH-entry fetch queue and redirect flush.
// Optional misaligned-redirect fault reporting is enabled by defining IF_MISALIGN_FAULT_EN.
module if_fetch_queue #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter int unsigned          ADDR_W   = 10,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_src,
  input  logic [XLEN-1:0]   branch_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [XLEN-1:0]   imem_rsp_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_instr
`ifdef IF_MISALIGN_FAULT_EN
  ,
  output logic              out_fault
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [XLEN-1:0]  instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PTR_W-1:0] head, fill, tail;
  logic [CNT_W-1:0] count, pend_cnt, drop_cnt;
  logic [CNT_W:0]   occupancy;
  logic             room, fetch_en, queue_valid;
  logic             req_fire, pop, rsp_drop, rsp_fill;

  // Stale responses still hold memory slots, so they count against the request budget.
  assign occupancy   = {1'b0, count} + {1'b0, drop_cnt};
  assign room        = occupancy < (CNT_W + 1)'(DEPTH);
  assign queue_valid = (count != '0) && filled_q[head] && !pc_src && fetch_en;

  assign imem_req_valid = reset && fetch_en && !pc_src && room;
  assign imem_req_addr  = fetch_pc[ADDR_W+1:2];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop      = queue_valid && out_ready;
  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0);

`ifdef IF_MISALIGN_FAULT_EN
  typedef enum logic [1:0] {ST_RUN, ST_FAULT, ST_IDLE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fault_pc;
  logic            fault_valid;

  assign fetch_en    = (state == ST_RUN);
  assign fault_valid = (state == ST_FAULT) && (drop_cnt == '0) && !pc_src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      fault_pc <= '0;
    end else begin
      state <= state_nxt;
      if (pc_src) fault_pc <= branch_pc;
    end
  end

  always_comb begin
    state_nxt = state;
    if (pc_src)
      state_nxt = (branch_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
    else if (fault_valid && out_ready)
      state_nxt = ST_IDLE;
  end

  assign out_valid = queue_valid || fault_valid;
  assign out_pc    = fault_valid ? fault_pc : pc_q[head];
  assign out_instr = fault_valid ? XLEN'(32'h0000_0013) : instr_q[head];
  assign out_fault = fault_valid;
`else
  assign fetch_en  = 1'b1;
  assign out_valid = queue_valid;
  assign out_pc    = pc_q[head];
  assign out_instr = instr_q[head];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      count    <= '0;
      pend_cnt <= '0;
      drop_cnt <= '0;
      filled_q <= '0;
      pc_q     <= '{default: '0};
      instr_q  <= '{default: '0};
    end else if (pc_src) begin
      // Every unfilled entry becomes a stale response, less one if it lands this cycle.
      fetch_pc <= branch_pc & ~XLEN'(3);
      head     <= tail;
      fill     <= tail;
      count    <= '0;
      pend_cnt <= '0;
      filled_q <= '0;
      drop_cnt <= drop_cnt + pend_cnt - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_q[tail]     <= fetch_pc;
        filled_q[tail] <= 1'b0;
        tail           <= tail + PTR_W'(1);
        fetch_pc       <= fetch_pc + XLEN'(4);
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end else if (rsp_fill) begin
        instr_q[fill]  <= imem_rsp_instr;
        filled_q[fill] <= 1'b1;
        fill           <= fill + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      count    <= count + CNT_W'(req_fire) - CNT_W'(pop);
      pend_cnt <= pend_cnt + CNT_W'(req_fire) - CNT_W'(rsp_fill);
    end
  end

endmodule
